multdiv_issue_ctrl: RTL and testbench

Initiator-side controller for the iterative multiplier/divider. It sits in the execute stage between the pipeline and the multdiv unit. It accepts a mult/div instruction and latches its operands, then issues a single-cycle start pulse. It stalls the pipeline until the unit raises its ready flag, and delivers the result, or an `$rstatus` exception write, to writeback exactly once. It also handles pipeline flushes that arrive mid-operation by draining and discarding the in-flight result.

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/md_timeout_counter.sv | 27 ++
 rtl/multdiv_issue_ctrl.sv | 119 +++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding and $rstatus constants for the multdiv issue controller
package multdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BUSY  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } md_state_e;

  localparam logic [31:0] RSTATUS_MULT_EXC = 32'd4;
  localparam logic [31:0] RSTATUS_DIV_EXC  = 32'd5;
  localparam logic [4:0]  RSTATUS_REG      = 5'd30;

  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? RSTATUS_DIV_EXC : RSTATUS_MULT_EXC;
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// rtl/md_timeout_counter.sv - BUSY-cycle watchdog, instantiated only when MULTDIV_TIMEOUT_EN is defined
module md_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [5:0] LAST = 6'(TIMEOUT_CYCLES - 1);

  logic [5:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= 6'd0;
    end else if (enable) begin
      count <= count + 6'd1;
    end
  end

  // Fires during the final allowed BUSY cycle so DONE follows on the next edge.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - multdiv issue/stall/writeback controller; watchdog under MULTDIV_TIMEOUT_EN
module multdiv_issue_ctrl #(
`ifdef MULTDIV_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 40,
`endif
  parameter logic [4:0] RSTATUS_REG = multdiv_pkg::RSTATUS_REG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  input  logic        flush,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  import multdiv_pkg::*;

  md_state_e   state, state_next;
  logic        is_div_q;
  logic [4:0]  rd_q;
  logic        wb_valid_q;
  logic        timeout_hit;
  logic        accept;
  logic        finish;
  logic        exc_now;

`ifdef MULTDIV_TIMEOUT_EN
  md_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == S_START),
    .enable  (state == S_BUSY),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      S_IDLE:  if (op_valid && !flush) state_next = S_START;
      S_START: state_next = flush ? S_DRAIN : S_BUSY;
      S_BUSY: begin
        if (flush) state_next = S_DRAIN;
        else if (md_resultRDY || timeout_hit) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      S_DRAIN: if (md_resultRDY) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // The op retires from X in DONE, so the pipeline is released alongside wb_valid.
    if (!flush && state != S_DONE) stall = op_valid;
  end

  assign accept  = (state == S_IDLE) && op_valid && !flush;
  assign finish  = (state == S_BUSY) && !flush && (md_resultRDY || timeout_hit);
  // A watchdog expiry without a real ready is reported as an exception.
  assign exc_now = md_resultRDY ? md_exception : 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_MULT    <= 1'b0;
      ctrl_DIV     <= 1'b0;
      md_operandA  <= 32'd0;
      md_operandB  <= 32'd0;
      is_div_q     <= 1'b0;
      rd_q         <= 5'd0;
      wb_valid_q   <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      wb_exception <= 1'b0;
    end else begin
      ctrl_MULT  <= accept && !op_is_div;
      ctrl_DIV   <= accept && op_is_div;
      wb_valid_q <= finish;
      if (accept) begin
        md_operandA <= op_a;
        md_operandB <= op_b;
        is_div_q    <= op_is_div;
        rd_q        <= op_rd;
      end
      if (finish) begin
        wb_exception <= exc_now;
        wb_rd        <= exc_now ? RSTATUS_REG : rd_q;
        wb_data      <= exc_now ? exc_code(is_div_q) : md_result;
      end
    end
  end

  // A flush landing on the DONE cycle cancels the writeback in that same cycle.
  assign wb_valid = wb_valid_q && !flush;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb/tb_multdiv_issue_ctrl.sv - directed self-checking bench for multdiv_issue_ctrl
module tb_multdiv_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid, op_is_div, flush;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] md_operandA, md_operandB;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic        stall, wb_valid, wb_exception;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s1, w1, s2, w2;

  multdiv_issue_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_is_div    (op_is_div),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_rd        (op_rd),
    .flush        (flush),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_exception (wb_exception)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle_cycle();
    next_cycle();
    op_valid     = 1'b0;
    flush        = 1'b0;
    md_resultRDY = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    check({tag, "_opa"}, md_operandA, 32'd0);
    check({tag, "_opb"}, md_operandB, 32'd0);
    check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    check({tag, "_wbrd"}, 32'(wb_rd), 32'd0);
    check({tag, "_wbdata"}, wb_data, 32'd0);
    check({tag, "_wbexc"}, 32'(wb_exception), 32'd0);
  endtask

  // Cycle c=0 is the accept cycle; the unit's ready is modelled in cycle k.
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int k, input logic give_rdy,
                        input logic [31:0] res, input logic exc, input int flush_at,
                        input logic [4:0] e_rd, input logic [31:0] e_data, input logic e_exc,
                        output int start_cyc, output int wb_cyc);
    logic exp_wb;
    start_cyc = -1;
    wb_cyc    = -1;
    for (int c = 0; c <= k + 1; c++) begin
      next_cycle();
      op_valid     = (c != flush_at);
      op_is_div    = is_div;
      op_a         = a;
      op_b         = b;
      op_rd        = rd;
      flush        = (c == flush_at);
      md_resultRDY = give_rdy && (c == k);
      md_result    = (c == k) ? res : 32'hdead_beef;
      md_exception = (c == k) ? exc : 1'b1;
      @(negedge clock);
      check("ctrl_mult", 32'(ctrl_MULT), 32'(c == 1 && !is_div));
      check("ctrl_div", 32'(ctrl_DIV), 32'(c == 1 && is_div));
      check("stall", 32'(stall), 32'(c <= k && c != flush_at));
      exp_wb = (c == k + 1) && (flush_at != k + 1);
      check("wb_valid", 32'(wb_valid), 32'(exp_wb));
      if (c == 1) begin
        start_cyc = cyc;
        check("operand_a", md_operandA, a);
        check("operand_b", md_operandB, b);
      end
      if (exp_wb) begin
        wb_cyc = cyc;
        check("wb_rd", 32'(wb_rd), 32'(e_rd));
        check("wb_data", wb_data, e_data);
        check("wb_exc", 32'(wb_exception), 32'(e_exc));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    op_valid = 1'b0; op_is_div = 1'b0; flush = 1'b0;
    op_a = 32'd0; op_b = 32'd0; op_rd = 5'd0;
    md_result = 32'd0; md_exception = 1'b0; md_resultRDY = 1'b0;
    repeat (3) next_cycle();
    @(negedge clock);
    check_all_zero("reset");
    check("reset_stall", 32'(stall), 32'd0);
    next_cycle();
    reset = 1'b0;

    // mult 7*6 -> rd 3, ready at cycle 33
    run_op(1'b0, 32'd7, 32'd6, 5'd3, 33, 1'b1, 32'd42, 1'b0, -1, 5'd3, 32'd42, 1'b0, s1, w1);
    idle_cycle();

    // div 10/0 with exception -> $rstatus = 5
    run_op(1'b1, 32'd10, 32'd0, 5'd7, 8, 1'b1, 32'd0, 1'b1, -1, 5'd30, 32'd5, 1'b1, s1, w1);
    idle_cycle();
    @(negedge clock);
    check("div_single_pulse", 32'(wb_valid), 32'd0);

    // flush in BUSY cycle 10, new op waits through DRAIN
    for (int c = 0; c <= 15; c++) begin
      next_cycle();
      flush        = (c == 10);
      op_valid     = (c != 10);
      op_is_div    = 1'b0;
      op_a         = (c < 10) ? 32'd5 : 32'd3;
      op_b         = (c < 10) ? 32'd5 : 32'd3;
      op_rd        = (c < 10) ? 5'd4 : 5'd9;
      md_resultRDY = (c == 15);
      md_result    = 32'd25;
      md_exception = 1'b0;
      @(negedge clock);
      check("flush_wbv", 32'(wb_valid), 32'd0);
      if (c >= 10) check("flush_ctrl", 32'(ctrl_MULT), 32'd0);
      if (c == 10) check("flush_stall", 32'(stall), 32'd0);
      if (c >= 11) check("drain_stall", 32'(stall), 32'd1);
    end
    run_op(1'b0, 32'd3, 32'd3, 5'd9, 4, 1'b1, 32'd9, 1'b0, -1, 5'd9, 32'd9, 1'b0, s1, w1);
    idle_cycle();

    // reset while BUSY
    for (int c = 0; c <= 5; c++) begin
      next_cycle();
      op_valid  = (c < 5);
      op_is_div = 1'b0;
      op_a      = 32'd100;
      op_b      = 32'd2;
      op_rd     = 5'd6;
      reset     = (c == 5);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("midreset");
    next_cycle();
    md_resultRDY = 1'b1;
    md_result    = 32'd200;
    @(negedge clock);
    check("stale_rdy_wbv", 32'(wb_valid), 32'd0);
    check("stale_rdy_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    idle_cycle();
    @(negedge clock);
    check("stale_rdy_wbv2", 32'(wb_valid), 32'd0);
    run_op(1'b1, 32'd20, 32'd4, 5'd11, 6, 1'b1, 32'd5, 1'b0, -1, 5'd11, 32'd5, 1'b0, s1, w1);

    // back-to-back mults, ready at k=5
    run_op(1'b0, 32'd12, 32'd11, 5'd5, 5, 1'b1, 32'd132, 1'b0, -1, 5'd5, 32'd132, 1'b0, s1, w1);
    run_op(1'b0, 32'h0000_ffff, 32'd2, 5'd6, 5, 1'b1, 32'h0001_fffe, 1'b0, -1, 5'd6, 32'h0001_fffe, 1'b0, s2, w2);
    check("b2b_gap", 32'(s2 - w1), 32'd2);
    idle_cycle();

    // flush on the DONE cycle suppresses writeback
    run_op(1'b0, 32'd2, 32'd2, 5'd8, 3, 1'b1, 32'd4, 1'b0, 4, 5'd8, 32'd4, 1'b0, s1, w1);
    idle_cycle();
    @(negedge clock);
    check("done_flush_wbv", 32'(wb_valid), 32'd0);

`ifdef MULTDIV_TIMEOUT_EN
    // ready never arrives: forced mult exception at cycle 42
    run_op(1'b0, 32'd1, 32'd2, 5'd3, 41, 1'b0, 32'd0, 1'b0, -1, 5'd30, 32'd4, 1'b1, s1, w1);
    idle_cycle();
    md_resultRDY = 1'b1;
    @(negedge clock);
    check("timeout_stray_wbv", 32'(wb_valid), 32'd0);
    idle_cycle();
    @(negedge clock);
    check("timeout_stray_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
